// File: rtl/apu_frame_counter.sv
`default_nettype none
// ============================================================================
// apu_frame_counter: NES APU frame sequencer (4/5-step), Q/H pulses, frame IRQ.
// Optional frame IRQ / $4015 status logic: define APU_FRAME_IRQ_EN.  Rev 1.0
// ============================================================================
module apu_frame_counter #(
  parameter int TICK_DIV = 28
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en_in,
  input  logic [15:0] a_in,
  input  logic        r_nw_in,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out_o,
  output logic        quarter_frame_o,
  output logic        half_frame_o,
  output logic        nirq_o
);

  localparam logic [7:0]  PRESC_LAST  = 8'(TICK_DIV - 1);
  localparam logic [15:0] STEP_1      = 16'd7457;
  localparam logic [15:0] STEP_2      = 16'd14913;
  localparam logic [15:0] STEP_3      = 16'd22371;
  localparam logic [15:0] STEP_4      = 16'd29829;
  localparam logic [15:0] STEP_5      = 16'd37281;
  localparam logic [15:0] ADDR_CTRL   = 16'h4017;

  typedef enum logic {
    SEQ_4STEP = 1'b0,
    SEQ_5STEP = 1'b1
  } seq_mode_t;

  seq_mode_t   mode;
  logic [7:0]  presc;
  logic [15:0] cnt;
  logic        sel_w;
  logic        sel_w_d;
  logic        wr_acc;
  logic        tick;
  logic        evt;
  logic        step_q;
  logic        step_h;
  logic        step_irq;
  logic        step_wrap;
  logic        qf;
  logic        hf;

  assign sel_w  = (a_in == ADDR_CTRL) && !r_nw_in;
  assign wr_acc = sel_w && !sel_w_d;
  assign tick   = (presc == PRESC_LAST) && en_in;
  // A $4017 write on a tick clk wins: the step event is dropped.
  assign evt    = tick && !wr_acc;

  always_comb begin
    step_q    = 1'b0;
    step_h    = 1'b0;
    step_irq  = 1'b0;
    step_wrap = 1'b0;
    if (evt) begin
      if (cnt == STEP_1 || cnt == STEP_3) begin
        step_q = 1'b1;
      end else if (cnt == STEP_2) begin
        step_q = 1'b1;
        step_h = 1'b1;
      end else if (mode == SEQ_4STEP && cnt == STEP_4) begin
        step_q    = 1'b1;
        step_h    = 1'b1;
        step_irq  = 1'b1;
        step_wrap = 1'b1;
      end else if (mode == SEQ_5STEP && cnt == STEP_5) begin
        step_q    = 1'b1;
        step_h    = 1'b1;
        step_wrap = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      presc   <= 8'd0;
      cnt     <= 16'd0;
      mode    <= SEQ_4STEP;
      sel_w_d <= 1'b0;
      qf      <= 1'b0;
      hf      <= 1'b0;
    end else begin
      sel_w_d <= sel_w;
      if (wr_acc) begin
        mode  <= d_in[7] ? SEQ_5STEP : SEQ_4STEP;
        cnt   <= 16'd0;
        presc <= 8'd0;
        qf    <= d_in[7];
        hf    <= d_in[7];
      end else begin
        if (en_in) begin
          presc <= (presc == PRESC_LAST) ? 8'd0 : presc + 8'd1;
        end
        if (tick) begin
          cnt <= step_wrap ? 16'd0 : cnt + 16'd1;
        end
        qf <= step_q;
        hf <= step_h;
      end
    end
  end

  assign quarter_frame_o = qf;
  assign half_frame_o    = hf;

`ifdef APU_FRAME_IRQ_EN
  localparam logic [15:0] ADDR_STATUS = 16'h4015;

  logic sel_r;
  logic sel_r_d;
  logic rd_end;
  logic inhibit;
  logic irq_flag;
  logic unused_bits;

  assign sel_r  = (a_in == ADDR_STATUS) && r_nw_in;
  // Clear after the read ends so the status byte stays stable during the access.
  assign rd_end = sel_r_d && !sel_r;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sel_r_d  <= 1'b0;
      inhibit  <= 1'b0;
      irq_flag <= 1'b0;
    end else begin
      sel_r_d <= sel_r;
      if (wr_acc) begin
        inhibit <= d_in[6];
      end
      if (wr_acc && d_in[6]) begin
        irq_flag <= 1'b0;
      end else if (step_irq && !inhibit) begin
        irq_flag <= 1'b1;
      end else if (rd_end) begin
        irq_flag <= 1'b0;
      end
    end
  end

  assign d_out_o     = sel_r ? {1'b0, irq_flag, 6'b0} : 8'h00;
  assign nirq_o      = ~irq_flag;
  assign unused_bits = ^d_in[5:0];
`else
  logic unused_bits;

  assign d_out_o     = 8'h00;
  assign nirq_o      = 1'b1;
  assign unused_bits = ^{d_in[6:0], step_irq};
`endif

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_counter.sv
`default_nettype none
// ============================================================================
// tb_apu_frame_counter: directed checks of the APU frame sequencer.  Rev 1.0
// ============================================================================
module tb_apu_frame_counter;

`ifdef APU_FRAME_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst  [3];
  logic        en   [3];
  logic [15:0] a    [3];
  logic        r_nw [3];
  logic [7:0]  d    [3];
  logic [7:0]  dout [3];
  logic        qf   [3];
  logic        hf   [3];
  logic        nirq [3];
  int          ncyc [3];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // Instances 0/1 tick every clk; instance 2 uses a real prescaler (TICK_DIV=2).
  apu_frame_counter #(.TICK_DIV(1)) u_a (
    .clk_in(clk), .rst_in(rst[0]), .en_in(en[0]), .a_in(a[0]), .r_nw_in(r_nw[0]),
    .d_in(d[0]), .d_out_o(dout[0]), .quarter_frame_o(qf[0]), .half_frame_o(hf[0]),
    .nirq_o(nirq[0]));
  apu_frame_counter #(.TICK_DIV(1)) u_b (
    .clk_in(clk), .rst_in(rst[1]), .en_in(en[1]), .a_in(a[1]), .r_nw_in(r_nw[1]),
    .d_in(d[1]), .d_out_o(dout[1]), .quarter_frame_o(qf[1]), .half_frame_o(hf[1]),
    .nirq_o(nirq[1]));
  apu_frame_counter #(.TICK_DIV(2)) u_c (
    .clk_in(clk), .rst_in(rst[2]), .en_in(en[2]), .a_in(a[2]), .r_nw_in(r_nw[2]),
    .d_in(d[2]), .d_out_o(dout[2]), .quarter_frame_o(qf[2]), .half_frame_o(hf[2]),
    .nirq_o(nirq[2]));

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int id, input int n);
    repeat (n) begin
      @(negedge clk);
      ncyc[id]++;
    end
  endtask

  task automatic run_to(input int id, input int e);
    while (ncyc[id] < e) cyc(id, 1);
  endtask

  // Edge e (counted from reset release or a $4017 write) is the one whose Q/H is visible.
  task automatic pulse(input int id, input string tag, input int e, input bit q, input bit h);
    run_to(id, e - 1);
    check_val({tag, " pre"}, {qf[id], hf[id]}, 2'b00);
    run_to(id, e);
    check_val(tag, {qf[id], hf[id]}, {q, h});
    run_to(id, e + 1);
    check_val({tag, " post"}, {qf[id], hf[id]}, 2'b00);
  endtask

  task automatic wr4017(input int id, input logic [7:0] v);
    a[id]    = 16'h4017;
    r_nw[id] = 1'b0;
    d[id]    = v;
    cyc(id, 1);
    a[id]    = 16'h0000;
    r_nw[id] = 1'b1;
    d[id]    = 8'h00;
    ncyc[id] = 0;
  endtask

  task automatic run_a();
    rst[0] = 1'b0;
    ncyc[0] = 0;
    pulse(0, "a q7457", 7458, 1'b1, 1'b0);
    pulse(0, "a qh14913", 14914, 1'b1, 1'b1);
    pulse(0, "a q22371", 22372, 1'b1, 1'b0);
    run_to(0, 29829);
    check_val("a nirq pre frame end", nirq[0], 1'b1);
    pulse(0, "a qh29829", 29830, 1'b1, 1'b1);
    check_val("a nirq after frame", nirq[0], !IRQ);
    // $4015 read held for three clocks.
    a[0] = 16'h4015;
    r_nw[0] = 1'b1;
    #1 check_val("a rd0", dout[0], IRQ ? 8'h40 : 8'h00);
    cyc(0, 1);
    check_val("a rd1", dout[0], IRQ ? 8'h40 : 8'h00);
    cyc(0, 1);
    check_val("a rd2", dout[0], IRQ ? 8'h40 : 8'h00);
    cyc(0, 1);
    a[0] = 16'h0000;
    #1 check_val("a rd deselect dout", dout[0], 8'h00);
    check_val("a nirq held at deselect", nirq[0], !IRQ);
    cyc(0, 1);
    check_val("a nirq after read", nirq[0], 1'b1);
    a[0] = 16'h4015;
    #1 check_val("a second rd", dout[0], 8'h00);
    cyc(0, 1);
    a[0] = 16'h0000;
    // 5-step mode.
    wr4017(0, 8'h80);
    check_val("a wr80 qh", {qf[0], hf[0]}, 2'b11);
    pulse(0, "a5 q7457", 7458, 1'b1, 1'b0);
    pulse(0, "a5 qh14913", 14914, 1'b1, 1'b1);
    pulse(0, "a5 q22371", 22372, 1'b1, 1'b0);
    pulse(0, "a5 quiet29829", 29830, 1'b0, 1'b0);
    check_val("a5 nirq mid", nirq[0], 1'b1);
    pulse(0, "a5 qh37281", 37282, 1'b1, 1'b1);
    check_val("a5 nirq end", nirq[0], 1'b1);
  endtask

  task automatic run_b();
    rst[1] = 1'b0;
    ncyc[1] = 0;
    run_to(1, 29830);
    check_val("b frame end qh", {qf[1], hf[1]}, 2'b11);
    check_val("b nirq set", nirq[1], !IRQ);
    pulse(1, "b next-frame q", 29830 + 7458, 1'b1, 1'b0);
    check_val("b nirq still set", nirq[1], !IRQ);
    // Inhibit write clears the pending IRQ and blocks the next one.
    wr4017(1, 8'h40);
    check_val("b inhibit clears", nirq[1], 1'b1);
    check_val("b wr40 no pulse", {qf[1], hf[1]}, 2'b00);
    pulse(1, "b4 q7457", 7458, 1'b1, 1'b0);
    pulse(1, "b4 qh14913", 14914, 1'b1, 1'b1);
    pulse(1, "b4 q22371", 22372, 1'b1, 1'b0);
    pulse(1, "b4 qh29829", 29830, 1'b1, 1'b1);
    check_val("b4 nirq inhibited", nirq[1], 1'b1);
  endtask

  task automatic run_c();
    rst[2] = 1'b0;
    ncyc[2] = 0;
    // Write lands on the edge carrying the cnt=7457 tick (edge 2*7458).
    run_to(2, 14915);
    check_val("c pre collide", {qf[2], hf[2]}, 2'b00);
    wr4017(2, 8'h00);
    check_val("c collide suppressed", {qf[2], hf[2]}, 2'b00);
    pulse(2, "c q after restart", 14916, 1'b1, 1'b0);
    // Stall 1000 clk, later 3 more: the H event at 2*14914 moves by 1003.
    run_to(2, 16001);
    en[2] = 1'b0;
    cyc(2, 1000);
    en[2] = 1'b1;
    run_to(2, 20001);
    en[2] = 1'b0;
    cyc(2, 3);
    en[2] = 1'b1;
    run_to(2, 29828);
    check_val("c unstalled slot quiet", {qf[2], hf[2]}, 2'b00);
    run_to(2, 30830);
    check_val("c stall pre", {qf[2], hf[2]}, 2'b00);
    run_to(2, 30831);
    check_val("c stalled qh", {qf[2], hf[2]}, 2'b11);
    #2 rst[2] = 1'b1;
    #1 check_val("c async rst qh", {qf[2], hf[2]}, 2'b00);
    check_val("c async rst nirq", nirq[2], 1'b1);
    check_val("c async rst dout", dout[2], 8'h00);
    @(negedge clk);
    rst[2] = 1'b0;
    ncyc[2] = 0;
    pulse(2, "c q after reset", 14916, 1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i]  = 1'b1;
      en[i]   = 1'b1;
      a[i]    = 16'h0000;
      r_nw[i] = 1'b1;
      d[i]    = 8'h00;
      ncyc[i] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val("reset qh", {qf[i], hf[i]}, 2'b00);
      check_val("reset nirq", nirq[i], 1'b1);
      check_val("reset dout", dout[i], 8'h00);
    end
    fork
      run_a();
      run_b();
      run_c();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, expected end before 100k clk");
    $fatal(1);
  end

endmodule
`default_nettype wire
